ntt_stream_scheduler: RTL and testbench

- Frame-level sequencer in front of parallel_NTT_top; one frame = one NTT.
- Accepts one frame of 4*N_PER_PROC coefficients on a ready/valid slave stream and distributes them round-robin to processors P0..P3.
- Pulses the datapath reset, raises start, waits for finish, then reads every processor back and emits the results on a ready/valid master stream with backpressure.
- Sits between the DMA/AXIS shim and parallel_NTT_top; it is the only driver of that block's control and data ports.

---
 rtl/ntt_stream_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_ntt_stream_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ntt_stream_scheduler
// Brief   : Frame sequencer in front of parallel_NTT_top. Loads one frame of
//           4*N_PER_PROC coefficients round-robin into P0..P3, runs the NTT,
//           then reads the processors back through a credit-limited skid FIFO
//           onto a ready/valid output stream.
// Revision: 1.0 - initial release
// ============================================================================
module ntt_stream_scheduler #(
   parameter int N_PER_PROC = 256,
   parameter int FIFO_DEPTH = 8,
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        ntt_rst_b,
   output logic        ntt_start,
   input  logic        ntt_finish,
   output logic [31:0] s_processor_din,
   output logic [1:0]  s_processor_num,
   output logic        s_processor_din_valid,
   output logic [1:0]  m_processor_num,
   output logic        m_processor_num_valid,
   input  logic [31:0] m_processor_dout,
   input  logic        m_processor_dout_valid,
   output logic        busy,
   output logic        err_len,
   output logic        err_timeout
);

   localparam int c_FRAME = 4 * N_PER_PROC;
   localparam int c_CW    = $clog2(c_FRAME) + 1;
   localparam int c_PW    = $clog2(FIFO_DEPTH);
   localparam int c_FW    = c_PW + 1;
   localparam int c_TW    = $clog2(TIMEOUT + 1);
   localparam int c_KW    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   localparam logic [c_CW-1:0] c_LAST      = c_CW'(c_FRAME - 1);
   localparam logic [c_CW-1:0] c_FRAME_CNT = c_CW'(c_FRAME);
   localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT - 1);
   localparam logic [c_KW-1:0] c_CLR_LAST  = c_KW'(CLR_CYCLES - 1);
   localparam logic [c_FW:0]   c_DEPTH     = (c_FW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_CLEAR  = 3'd1;
   localparam logic [2:0] c_LOAD   = 3'd2;
   localparam logic [2:0] c_START  = 3'd3;
   localparam logic [2:0] c_WAIT   = 3'd4;
   localparam logic [2:0] c_UNLOAD = 3'd5;

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [c_KW-1:0] r_clr_cnt;
   logic [c_CW-1:0] r_in_idx;
   logic [c_TW-1:0] r_wait_cnt;
   logic [c_CW-1:0] r_rd_idx;
   logic [c_CW-1:0] r_out_idx;
   logic [c_FW-1:0] r_outstanding;
   logic [c_FW-1:0] r_fifo_cnt;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [31:0]     r_mem [FIFO_DEPTH];
   logic            r_err_len;
   logic            r_err_timeout;
   logic            r_ntt_rst_b;

   logic w_load_fire;
   logic w_load_done;
   logic w_timeout;
   logic w_credit_ok;
   logic w_issue;
   logic w_push;
   logic w_fifo_ne;
   logic w_pop;
   logic w_unload_done;

   assign w_load_fire   = (r_state == c_LOAD) && s_axis_tvalid;
   assign w_load_done   = w_load_fire && (r_in_idx == c_LAST);
   assign w_timeout     = (r_state == c_WAIT) && !ntt_finish && (r_wait_cnt == c_TO_LAST);
   // Requests in flight plus words already buffered can never exceed the FIFO.
   assign w_credit_ok   = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < c_DEPTH;
   assign w_issue       = (r_state == c_UNLOAD) && (r_rd_idx != c_FRAME_CNT) && w_credit_ok;
   // Returns with nothing outstanding are leftovers from an aborted frame.
   assign w_push        = (r_state == c_UNLOAD) && m_processor_dout_valid && (r_outstanding != '0);
   assign w_fifo_ne     = (r_fifo_cnt != '0);
   assign w_pop         = (r_state == c_UNLOAD) && w_fifo_ne && m_axis_tready;
   assign w_unload_done = w_pop && (r_out_idx == c_LAST);

   assign ntt_rst_b   = r_ntt_rst_b;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (s_axis_tvalid) w_next_state = c_CLEAR;
         c_CLEAR:  if (r_clr_cnt == c_CLR_LAST) w_next_state = c_LOAD;
         c_LOAD:   if (w_load_done) w_next_state = c_START;
         c_START:  w_next_state = c_WAIT;
         c_WAIT: begin
            if (ntt_finish)     w_next_state = c_UNLOAD;
            else if (w_timeout) w_next_state = c_IDLE;
         end
         c_UNLOAD: if (w_unload_done) w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   // Per-state outputs; load/read strobes are combinational with their handshake.
   always_comb begin
      s_axis_tready         = 1'b0;
      ntt_start             = 1'b0;
      s_processor_din       = '0;
      s_processor_num       = '0;
      s_processor_din_valid = 1'b0;
      m_processor_num       = '0;
      m_processor_num_valid = 1'b0;
      m_axis_tdata          = '0;
      m_axis_tvalid         = 1'b0;
      m_axis_tlast          = 1'b0;
      busy                  = (r_state != c_IDLE);
      case (r_state)
         c_LOAD: begin
            s_axis_tready = 1'b1;
            if (w_load_fire) begin
               s_processor_din       = s_axis_tdata;
               s_processor_num       = r_in_idx[1:0];
               s_processor_din_valid = 1'b1;
            end
         end
         c_START, c_WAIT: ntt_start = 1'b1;
         c_UNLOAD: begin
            if (w_issue) begin
               m_processor_num       = r_rd_idx[1:0];
               m_processor_num_valid = 1'b1;
            end
            if (w_fifo_ne) begin
               m_axis_tdata  = r_mem[r_rd_ptr];
               m_axis_tvalid = 1'b1;
               m_axis_tlast  = (r_out_idx == c_LAST);
            end
         end
         default: ;
      endcase
   end

   // Frame counters, credit tracking, FIFO pointers, sticky errors, datapath reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_cnt     <= '0;
         r_in_idx      <= '0;
         r_wait_cnt    <= '0;
         r_rd_idx      <= '0;
         r_out_idx     <= '0;
         r_outstanding <= '0;
         r_fifo_cnt    <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_ntt_rst_b   <= 1'b0;
      end else begin
         r_clr_cnt  <= (r_state == c_CLEAR) ? r_clr_cnt + 1'b1 : '0;
         r_wait_cnt <= (r_state == c_WAIT) ? r_wait_cnt + 1'b1 : '0;

         if (r_state != c_LOAD)  r_in_idx <= '0;
         else if (w_load_fire)   r_in_idx <= w_load_done ? '0 : r_in_idx + 1'b1;

         if (r_state == c_UNLOAD) begin
            if (w_issue) r_rd_idx  <= r_rd_idx + 1'b1;
            if (w_pop)   r_out_idx <= r_out_idx + 1'b1;
         end else begin
            r_rd_idx  <= '0;
            r_out_idx <= '0;
         end

         case ({w_issue, w_push})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= (r_state == c_IDLE) ? '0 : r_outstanding;
         endcase

         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase

         if (w_load_fire && ((r_in_idx == c_LAST) != s_axis_tlast)) r_err_len <= 1'b1;
         if (w_timeout) r_err_timeout <= 1'b1;

         // Low through CLEAR, and for the single IDLE cycle that follows a timeout.
         r_ntt_rst_b <= (w_next_state != c_CLEAR) && !w_timeout;
      end
   end

   // Skid FIFO storage; flushing is done through the pointers alone.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= m_processor_dout;
   end

endmodule
`default_nettype wire

// File: tb/tb_ntt_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_ntt_stream_scheduler
// Brief   : Self-checking bench for ntt_stream_scheduler with a behavioural
//           four-processor datapath (3-cycle read latency, programmable
//           finish delay) and a queue scoreboard of expected output words.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ntt_stream_scheduler;

   localparam int N     = 4;
   localparam int FRAME = 4 * N;
   localparam int DEPTH = 4;
   localparam int TO    = 50;
   localparam logic [31:0] XMASK = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        ntt_rst_b;
   logic        ntt_start;
   logic        ntt_finish = 1'b0;
   logic [31:0] s_processor_din;
   logic [1:0]  s_processor_num;
   logic        s_processor_din_valid;
   logic [1:0]  m_processor_num;
   logic        m_processor_num_valid;
   logic [31:0] m_processor_dout = '0;
   logic        m_processor_dout_valid = 1'b0;
   logic        busy;
   logic        err_len;
   logic        err_timeout;

   always #5 clk = ~clk;

   ntt_stream_scheduler #(
      .N_PER_PROC(N), .FIFO_DEPTH(DEPTH), .CLR_CYCLES(2), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .ntt_rst_b(ntt_rst_b), .ntt_start(ntt_start), .ntt_finish(ntt_finish),
      .s_processor_din(s_processor_din), .s_processor_num(s_processor_num),
      .s_processor_din_valid(s_processor_din_valid),
      .m_processor_num(m_processor_num), .m_processor_num_valid(m_processor_num_valid),
      .m_processor_dout(m_processor_dout), .m_processor_dout_valid(m_processor_dout_valid),
      .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   // scoreboard / monitor state
   logic [31:0] exp_q[$];
   int in_cnt, out_cnt, start_rises, start_hi, req_cnt, pop_cnt, max_inflight;
   logic mon_prev_start = 1'b0;

   // datapath model state
   logic [31:0] pmem [4][4];
   int   wptr[4];
   int   rptr[4];
   logic [31:0] pipe_d[3];
   logic pipe_v[3];
   logic model_prev_start = 1'b0;
   logic fin_armed = 1'b0;
   int   fin_cnt = 0;
   int   fin_delay = 20;
   logic fin_never = 1'b0;

   int   rdy_mode = 0;
   int   rdy_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic clear_frame_stats();
      in_cnt = 0; out_cnt = 0; start_rises = 0; start_hi = 0;
      req_cnt = 0; pop_cnt = 0; max_inflight = 0;
   endtask

   task automatic monitor_step();
      if (s_axis_tvalid && s_axis_tready) begin
         check_eq("load_strobe", 32'(s_processor_din_valid), 32'd1);
         check_eq("load_num", 32'(s_processor_num), 32'(in_cnt % 4));
         check_eq("load_data", s_processor_din, s_axis_tdata);
         exp_q.push_back(s_axis_tdata ^ XMASK);
         in_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         check_eq("out_q_avail", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check_eq("out_data", m_axis_tdata, exp_q.pop_front());
         check_eq("out_last", 32'(m_axis_tlast), 32'(out_cnt == FRAME - 1));
         out_cnt++;
         pop_cnt++;
      end
      if (m_processor_num_valid) req_cnt++;
      if (req_cnt - pop_cnt > max_inflight) max_inflight = req_cnt - pop_cnt;
      if (ntt_start && !mon_prev_start) start_rises++;
      if (ntt_start) start_hi++;
      mon_prev_start = ntt_start;
   endtask

   task automatic model_step();
      logic rise;
      rise = ntt_start && !model_prev_start;
      model_prev_start = ntt_start;
      if (!ntt_rst_b) begin
         for (int p = 0; p < 4; p++) begin wptr[p] = 0; rptr[p] = 0; end
         fin_armed = 1'b0; fin_cnt = 0; ntt_finish = 1'b0;
      end else begin
         if (s_processor_din_valid) begin
            pmem[s_processor_num][wptr[s_processor_num] % N] = s_processor_din;
            wptr[s_processor_num]++;
         end
         if (rise) begin
            fin_armed = 1'b1; fin_cnt = 0;
         end else if (fin_armed && !fin_never) begin
            fin_cnt++;
            if (fin_cnt >= fin_delay) ntt_finish = 1'b1;
         end
      end
      // read pipe keeps running through resets so stale returns reach the DUT
      m_processor_dout_valid = pipe_v[2];
      m_processor_dout       = pipe_d[2];
      pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
      pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
      pipe_v[0] = m_processor_num_valid;
      pipe_d[0] = '0;
      if (m_processor_num_valid) begin
         pipe_d[0] = pmem[m_processor_num][rptr[m_processor_num] % N] ^ XMASK;
         rptr[m_processor_num]++;
      end
   endtask

   task automatic negedge_loop();
      forever begin
         @(negedge clk);
         monitor_step();
         model_step();
      end
   endtask

   task automatic ready_loop();
      forever begin
         @(posedge clk);
         #1;
         rdy_cyc++;
         m_axis_tready = (rdy_mode == 0) || (rdy_cyc % 3 == 0);
      end
   endtask

   task automatic send_frame(input logic [31:0] base, input int last_beat);
      int guard;
      for (int i = 0; i < FRAME; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = base + 32'(i);
         s_axis_tlast  = (i == last_beat);
         guard = 0;
         forever begin
            @(negedge clk);
            if (s_axis_tready || guard > 200) break;
            guard++;
         end
         if (!s_axis_tready) begin
            check_eq("load_ready_bound", 32'(s_axis_tready), 32'd1);
            s_axis_tvalid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_done(input string pfx);
      int guard = 0;
      while (out_cnt < FRAME && guard < 3000) begin
         @(negedge clk); #1;
         guard++;
      end
      check_eq({pfx, "_out_count"}, 32'(out_cnt), 32'(FRAME));
      @(negedge clk); #1;
      check_eq({pfx, "_busy_after"}, 32'(busy), 32'd0);
      check_eq({pfx, "_in_count"}, 32'(in_cnt), 32'(FRAME));
      check_eq({pfx, "_start_rises"}, 32'(start_rises), 32'd1);
      check_eq({pfx, "_credit"}, 32'(max_inflight <= DEPTH), 32'd1);
      check_eq({pfx, "_reads"}, 32'(req_cnt), 32'(FRAME));
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 3; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
      for (int p = 0; p < 4; p++) begin wptr[p] = 0; rptr[p] = 0; end
      clear_frame_stats();
      fork
         negedge_loop();
         ready_loop();
         begin
            #400000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog expired");
         end
      join_none

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_eq("rst_ntt_rst_b", 32'(ntt_rst_b), 32'd0);
      check_eq("rst_ctrl", 32'({s_axis_tready, m_axis_tvalid, m_axis_tlast, ntt_start,
                               s_processor_din_valid, m_processor_num_valid, busy,
                               err_len, err_timeout}), 32'd0);
      check_eq("rst_tdata", m_axis_tdata, 32'd0);
      check_eq("rst_din", s_processor_din, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_eq("idle_ntt_rst_b", 32'(ntt_rst_b), 32'd1);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_tready", 32'(s_axis_tready), 32'd0);

      // frame A: plain frame, full-rate sink
      @(posedge clk); #1;
      clear_frame_stats();
      send_frame(32'd0, FRAME - 1);
      wait_done("a");
      check_eq("a_err_len", 32'(err_len), 32'd0);
      check_eq("a_err_timeout", 32'(err_timeout), 32'd0);

      // frame B: sink ready one cycle in three
      @(posedge clk); #1;
      rdy_mode = 1;
      clear_frame_stats();
      send_frame(32'h0000_0100, FRAME - 1);
      wait_done("b");
      rdy_mode = 0;

      // frame C: early tlast on beat 9
      @(posedge clk); #1;
      clear_frame_stats();
      send_frame(32'h0000_0200, 9);
      @(negedge clk); #1;
      check_eq("c_tready_after_load", 32'(s_axis_tready), 32'd0);
      wait_done("c");
      check_eq("c_err_len", 32'(err_len), 32'd1);

      // frame D: finish never arrives
      @(posedge clk); #1;
      fin_never = 1'b1;
      clear_frame_stats();
      send_frame(32'h0000_0300, FRAME - 1);
      guard = 0;
      while (!err_timeout && guard < 400) begin
         @(negedge clk); #1;
         guard++;
      end
      check_eq("d_err_timeout", 32'(err_timeout), 32'd1);
      check_eq("d_start_cycles", 32'(start_hi), 32'(TO + 1));
      check_eq("d_busy", 32'(busy), 32'd0);
      check_eq("d_rst_b_pulse", 32'(ntt_rst_b), 32'd0);
      check_eq("d_no_output", 32'(out_cnt), 32'd0);
      @(negedge clk); #1;
      check_eq("d_rst_b_release", 32'(ntt_rst_b), 32'd1);
      exp_q.delete();
      fin_never = 1'b0;

      // frame E: recovery after timeout, flag stays sticky
      @(posedge clk); #1;
      clear_frame_stats();
      send_frame(32'h0000_0400, FRAME - 1);
      wait_done("e");
      check_eq("e_err_timeout_sticky", 32'(err_timeout), 32'd1);

      // frame F: reset in the middle of unload
      @(posedge clk); #1;
      rdy_mode = 1;
      clear_frame_stats();
      send_frame(32'h0000_0500, FRAME - 1);
      guard = 0;
      while (out_cnt < 6 && guard < 2000) begin
         @(negedge clk); #1;
         guard++;
      end
      check_eq("f_reached_word6", 32'(out_cnt >= 6), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      check_eq("f_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_eq("f_rst_busy", 32'(busy), 32'd0);
      check_eq("f_rst_ntt_rst_b", 32'(ntt_rst_b), 32'd0);
      check_eq("f_rst_rdreq", 32'(m_processor_num_valid), 32'd0);
      check_eq("f_rst_errs", 32'({err_len, err_timeout}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rdy_mode = 0;
      exp_q.delete();
      repeat (6) @(posedge clk);
      #1;

      // frame G: fresh frame after the abort
      clear_frame_stats();
      send_frame(32'h0000_0600, FRAME - 1);
      wait_done("g");
      check_eq("g_errs", 32'({err_len, err_timeout}), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
